// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, FSM encoding, NZP bit indices and legality decode for the operate sequencer
package lc3_pkg;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
    function automatic logic is_legal(input logic [15:0] inst);
        return inst[15:12] == OP_ADD || inst[15:12] == OP_AND ||
               (inst[15:12] == OP_NOT && inst[5:0] == 6'h3f);
    endfunction
endpackage

// File: rtl/lc3_operate_ctrl_if.sv
// lc3_operate_ctrl_if: instruction handshake, register-file, ALU and status signals of the sequencer
interface lc3_operate_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int RADDR_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_inst;
    logic [RADDR_W-1:0] rf_raddr1;
    logic [RADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0]  rf_rdata1;
    logic [DATA_W-1:0]  rf_rdata2;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [3:0]         alu_op;
    logic [DATA_W-1:0]  alu_out;
    logic [2:0]         nzp;
    logic               done;
    logic               err;
    logic               busy;
    modport master (
        input  in_valid, in_inst, rf_rdata1, rf_rdata2, alu_out,
        output in_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, nzp, done, err, busy
    );
    modport slave (
        output in_valid, in_inst, rf_rdata1, rf_rdata2, alu_out,
        input  in_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, nzp, done, err, busy
    );
endinterface

// File: rtl/lc3_sext.sv
// lc3_sext: sign-extends an IN_W-bit field to OUT_W bits
module lc3_sext #(
    parameter int IN_W = 5,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
endmodule

// File: rtl/lc3_operate_ctrl.sv
// lc3_operate_ctrl: sequences ADD/AND/NOT through read, registered ALU and write-back, owning NZP
module lc3_operate_ctrl
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RADDR_W = 3,
    parameter logic [2:0] NZP_RESET = 3'b010
) (
    input logic clk,
    input logic rst,
    lc3_operate_ctrl_if.master bus
);
    state_t state, state_nx;
    logic [15:0] inst;
    logic rej;
    logic [DATA_W-1:0] imm, a_r, b_r;
    logic [2:0] nzp_r;
    lc3_sext #(.IN_W(5), .OUT_W(DATA_W)) u_sext (.din(inst[4:0]), .dout(imm));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            inst <= '0;
            rej <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            nzp_r <= NZP_RESET;
        end else begin
            state <= state_nx;
            rej <= state == S_IDLE && bus.in_valid && !is_legal(bus.in_inst);
            if (state == S_IDLE && bus.in_valid) inst <= bus.in_inst;
            if (state == S_READ) begin
                a_r <= bus.rf_rdata1;
                b_r <= inst[15:12] == OP_NOT ? '0 : inst[5] ? imm : bus.rf_rdata2;
            end
            if (state == S_WB) begin
                nzp_r[NZP_N] <= bus.alu_out[DATA_W-1];
                nzp_r[NZP_Z] <= bus.alu_out == '0;
                nzp_r[NZP_P] <= !bus.alu_out[DATA_W-1] && bus.alu_out != '0;
            end
        end
    end
    always_comb begin
        state_nx = state == S_IDLE ? (bus.in_valid && is_legal(bus.in_inst) ? S_READ : S_IDLE) :
                   state == S_READ ? S_EXEC :
                   state == S_EXEC ? S_WB : S_IDLE;
    end
    always_comb begin
        bus.in_ready = state == S_IDLE;
        bus.busy = state != S_IDLE;
        bus.rf_raddr1 = RADDR_W'(inst[8:6]);
        bus.rf_raddr2 = RADDR_W'(inst[2:0]);
        bus.rf_we = state == S_WB;
        bus.rf_waddr = RADDR_W'(inst[11:9]);
        bus.rf_wdata = state == S_WB ? bus.alu_out : '0;
        bus.alu_a = a_r;
        bus.alu_b = b_r;
        bus.alu_op = state == S_EXEC ? inst[15:12] : 4'b0000;
        bus.nzp = nzp_r;
        bus.done = state == S_WB || rej;
        bus.err = rej;
    end
endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// tb_lc3_operate_ctrl: table vectors, reset corner cases and random instructions against an architectural model
module tb_lc3_operate_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3_operate_ctrl_if bus ();
    lc3_operate_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] rf [8];
    logic [15:0] init_rf [8];
    logic load;
    logic [15:0] alu_q;
    always @(posedge clk) begin
        if (load) rf <= init_rf;
        else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    always @(posedge clk) begin
        case (bus.alu_op)
            4'b0001: alu_q <= bus.alu_a + bus.alu_b;
            4'b0101: alu_q <= bus.alu_a & bus.alu_b;
            4'b1001: alu_q <= ~bus.alu_a;
            default: alu_q <= alu_q;
        endcase
    end
    assign bus.alu_out = alu_q;
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    int checks = 0;
    int errors = 0;
    logic [15:0] mrf [8];
    logic [2:0] mnzp;
    logic obs_err;
    logic [15:0] obs_wdata;
    logic [2:0] obs_nzp;

    typedef struct {
        logic [15:0] inst;
        logic        err;
        logic [15:0] wdata;
        logic [2:0]  nzp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after retirement.
    task automatic run(input logic [15:0] inst);
        logic [3:0] op;
        logic legal;
        int v, lat;
        logic [15:0] a, b, res;
        logic [2:0] enzp;
        op = inst[15:12];
        legal = op == 4'd1 || op == 4'd5 || (op == 4'd9 && inst[5:0] == 6'h3f);
        v = int'(inst[4:0]);
        if (v > 15) v -= 32;
        a = mrf[inst[8:6]];
        b = op == 4'd9 ? 16'd0 : inst[5] ? 16'(v) : mrf[inst[2:0]];
        res = op == 4'd1 ? a + b : op == 4'd5 ? a & b : ~a;
        enzp = !legal ? mnzp : res[15] ? 3'b100 : res == 16'd0 ? 3'b010 : 3'b001;
        lat = legal ? 3 : 1;
        chk("ready_before", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_inst = inst;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_inst = 16'($urandom);
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            chk("done", bus.done, i == lat);
            chk("rf_we", bus.rf_we, legal && i == lat);
            chk("alu_op", bus.alu_op, (legal && i == 2) ? op : 4'd0);
            if (legal && i < lat) chk("ready_busy", bus.in_ready, 0);
            if (legal && i == 2) begin
                chk("alu_a", bus.alu_a, a);
                chk("alu_b", bus.alu_b, b);
            end
            if (i == lat) begin
                obs_err = bus.err;
                obs_wdata = bus.rf_wdata;
                chk("err", bus.err, !legal);
                if (legal) begin
                    chk("waddr", bus.rf_waddr, inst[11:9]);
                    chk("wdata", bus.rf_wdata, res);
                end
            end
        end
        @(negedge clk);
        obs_nzp = bus.nzp;
        chk("nzp", bus.nzp, enzp);
        chk("done_low", bus.done, 0);
        chk("ready_after", bus.in_ready, 1);
        if (legal) mrf[inst[11:9]] = res;
        mnzp = enzp;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_inst = 16'h0000;
        init_rf = '{16'd5, 16'd7, 16'd0, 16'd1, 16'd0, 16'h1234, 16'h8000, 16'd0};
        mrf = init_rf;
        mnzp = 3'b010;
        vecs[0] = '{16'h1401, 1'b0, 16'd12,   3'b001};
        vecs[1] = '{16'h16FF, 1'b0, 16'd0,    3'b010};
        vecs[2] = '{16'h5960, 1'b0, 16'd0,    3'b010};
        vecs[3] = '{16'h9D3F, 1'b0, 16'hFFFF, 3'b100};
        vecs[4] = '{16'h2000, 1'b1, 16'd0,    3'b100};
        vecs[5] = '{16'h9D00, 1'b1, 16'd0,    3'b100};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        @(negedge clk);
        chk("rst_nzp", bus.nzp, 3'b010);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_we", bus.rf_we, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_aluop", bus.alu_op, 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        chk("rst_alua", bus.alu_a, 0);
        for (int t = 0; t < 6; t++) begin
            run(vecs[t].inst);
            chk("tbl_err", obs_err, vecs[t].err);
            if (!vecs[t].err) chk("tbl_wdata", obs_wdata, vecs[t].wdata);
            chk("tbl_nzp", obs_nzp, vecs[t].nzp);
        end
        // Abort an ADD with reset during its EXEC cycle.
        bus.in_valid = 1'b1;
        bus.in_inst = 16'h1401;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mnzp = 3'b010;
        for (int i = 0; i < 3; i++) begin
            chk("abort_done", bus.done, 0);
            chk("abort_we", bus.rf_we, 0);
            chk("abort_nzp", bus.nzp, 3'b010);
            chk("abort_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        run(16'h1A3F);
        for (int i = 0; i < 8; i++) begin
            init_rf[i] = 16'($urandom);
            mrf[i] = init_rf[i];
        end
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 0; n < 60; n++) begin
            int r;
            logic [15:0] inst;
            r = $urandom_range(0, 9);
            inst = 16'($urandom);
            if (r < 3) inst[15:12] = 4'b0001;
            else if (r < 6) inst[15:12] = 4'b0101;
            else if (r < 9) begin
                inst[15:12] = 4'b1001;
                inst[5:0] = 6'h3f;
            end
            run(inst);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 8; i++) chk("rf_final", rf[i], mrf[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
